// File: rtl/led_blink_1.sv
// Free-running LED blinker: divides clk down to a visible square wave on one pin.
// Contains a 2-flop reset synchronizer, a half-period prescaler and a polarity-aware output flop.
module led_blink_1 #(
    parameter int CLK_FREQ_HZ    = 50_000_000,
    parameter int BLINK_FREQ_HZ  = 1,
    parameter bit LED_ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst_async,
    output logic led
);

    localparam int HALF  = (BLINK_FREQ_HZ > 0) ? CLK_FREQ_HZ / (2 * BLINK_FREQ_HZ) : 0;
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

    generate
        if (BLINK_FREQ_HZ == 0) begin : g_bad_blink
            $error("led_blink_1: BLINK_FREQ_HZ must be non-zero");
        end
        if (HALF < 2) begin : g_bad_half
            $error("led_blink_1: half period must be at least 2 clock cycles");
        end
    endgenerate

    logic [1:0]       sync_q, sync_d;
    logic             rst_n_sync;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             led_q, led_d;

    always_comb begin
        sync_d = {sync_q[0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_async) begin
        if (!rst_async) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rst_n_sync = sync_q[1];

    // led_q holds the pin level itself so a toggle reaches the pin on the wrap edge.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        led_d = led_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            led_d = ~led_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            cnt_q <= '0;
            led_q <= LED_ACTIVE_LOW;
        end else begin
            cnt_q <= cnt_d;
            led_q <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_led_blink_1.sv
// Directed bench for led_blink_1: four parameterisations share one clock and reset,
// expected pin levels are derived from the edge count since reset release.
module tb_led_blink_1;

    logic clk = 1'b0;
    logic rst_async;
    logic led_h5, led_h5n, led_h2, led_h8;

    always #10 clk = ~clk;

    led_blink_1 #(.CLK_FREQ_HZ(20), .BLINK_FREQ_HZ(2), .LED_ACTIVE_LOW(1'b0)) u_h5 (
        .clk(clk), .rst_async(rst_async), .led(led_h5));
    led_blink_1 #(.CLK_FREQ_HZ(20), .BLINK_FREQ_HZ(2), .LED_ACTIVE_LOW(1'b1)) u_h5n (
        .clk(clk), .rst_async(rst_async), .led(led_h5n));
    led_blink_1 #(.CLK_FREQ_HZ(4), .BLINK_FREQ_HZ(1), .LED_ACTIVE_LOW(1'b0)) u_h2 (
        .clk(clk), .rst_async(rst_async), .led(led_h2));
    led_blink_1 #(.CLK_FREQ_HZ(17), .BLINK_FREQ_HZ(1), .LED_ACTIVE_LOW(1'b0)) u_h8 (
        .clk(clk), .rst_async(rst_async), .led(led_h8));

    typedef struct {
        int    d;
        logic  e;
        string tag;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  n_fail   = 0;
    bit  rel      = 1'b0;
    int  k        = 0;

    function automatic int half_of(int d);
        case (d)
            0:       return 5;
            1:       return 5;
            2:       return 2;
            default: return 8;
        endcase
    endfunction

    function automatic logic pol_of(int d);
        return (d == 1) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic led_of(int d);
        case (d)
            0:       return led_h5;
            1:       return led_h5n;
            2:       return led_h2;
            default: return led_h8;
        endcase
    endfunction

    // Two sync edges, then the first toggle after a further HALF edges.
    function automatic logic exp_led(int d, bit released, int kk);
        logic s;
        if (!released) return pol_of(d);
        s = (kk < 2) ? 1'b0 : logic'(((kk - 2) / half_of(d)) % 2);
        return s ^ pol_of(d);
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_all(string tag, bit released, int kk);
        for (int d = 0; d < 4; d++) begin
            sb_t it;
            it.d   = d;
            it.e   = exp_led(d, released, kk);
            it.tag = $sformatf("%s k%0d", tag, kk);
            sb_q.push_back(it);
        end
    endtask

    task automatic drain();
        while (sb_q.size() > 0) begin
            sb_t it;
            it = sb_q.pop_front();
            check($sformatf("%s dut%0d", it.tag, it.d), 32'(led_of(it.d)), 32'(it.e));
        end
    endtask

    task automatic tick(string tag);
        push_all(tag, rel, rel ? k + 1 : 0);
        @(posedge clk);
        if (rel) k++;
        #1;
        drain();
    endtask

    task automatic ticks(string tag, int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic assert_rst();
        rst_async = 1'b0;
        rel       = 1'b0;
        k         = 0;
    endtask

    task automatic release_rst();
        rst_async = 1'b1;
        rel       = 1'b1;
        k         = 0;
    endtask

    initial begin
        // Give the synchronizer a defined high level so the first reset is a real falling edge.
        rst_async = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        assert_rst();
        #1;
        push_all("reset_immediate", 1'b0, 0);
        drain();
        ticks("reset", 3);
        check("cnt_h5 in reset", 32'(u_h5.cnt_q), 32'd0);
        check("cnt_h8 in reset", 32'(u_h8.cnt_q), 32'd0);

        release_rst();
        ticks("run", 20);

        // Pin lit on the HALF=5 instance; pull reset 5 ns after the edge.
        check("h5 lit before async", 32'(led_h5), 32'd1);
        #4;
        assert_rst();
        #1;
        push_all("async", 1'b0, 0);
        drain();
        check("cnt_h5 after async", 32'(u_h5.cnt_q), 32'd0);
        check("cnt_h8 after async", 32'(u_h8.cnt_q), 32'd0);
        ticks("async_hold", 1);

        release_rst();
        ticks("rerun_a", 3);
        assert_rst();
        ticks("rereset", 1);
        check("cnt_h5 re-reset", 32'(u_h5.cnt_q), 32'd0);
        release_rst();
        ticks("rerun_b", 18);

        // 3 ns glitch between edges, mid-blink.
        #4;
        assert_rst();
        #1;
        push_all("glitch", 1'b0, 0);
        drain();
        #2;
        release_rst();
        ticks("post_glitch", 20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/led_blink_1.md
Name: led_blink_1

Overview:
- Free-running LED blinker for the MAX10 eval-kit playground.
- Divides the board clock (50 MHz default) down to a visible square wave and drives one LED pin.
- Contains an internal reset synchronizer, a half-period prescaler counter and a registered LED output with selectable pin polarity.
- Top-level leaf: no handshakes, no data inputs.

Parameters:
- CLK_FREQ_HZ, 50_000_000, input clock frequency in Hz.
- BLINK_FREQ_HZ, 1, LED blink frequency in Hz (one full on+off cycle per period).
- LED_ACTIVE_LOW, 0, 1 = LED lit when pin low (output inverted); 0 = lit when pin high.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_async  input  1  asynchronous active-low reset (0 = reset).
- led  output  1  LED drive pin, registered.

Behaviour:
- Derived constant HALF = CLK_FREQ_HZ / (2*BLINK_FREQ_HZ), integer division.
  - Elaboration error if HALF < 2, or if BLINK_FREQ_HZ = 0.
  - Counter width = $clog2(HALF), minimum 1 bit.
- Reset synchronizer: two flip-flops, async clear on rst_async = 0, shifting in 1 on each rising edge while rst_async = 1.
  - Internal reset rst_n_sync = second flop output.
  - Assertion is immediate and asynchronous; deassertion is synchronous, 2 rising edges after rst_async rises.
- While rst_n_sync = 0 (including asynchronously on rst_async falling):
  - counter = 0
  - led_state = 0
  - led = LED_ACTIVE_LOW, i.e. LED off
- Counting, on each rising edge with rst_n_sync = 1:
  - If counter == HALF-1: counter <= 0 and led_state <= ~led_state.
  - Else: counter <= counter + 1.
  - Counter never exceeds HALF-1; wrap is exact, with no off-by-one drift.
- Output: led = led_state XOR LED_ACTIVE_LOW, driven from a flop with no combinational path from rst_async except via async clear.
- Timing from rst_async rising, counting rising edges:
  - First led toggle (LED on) at edge HALF+2.
  - Subsequent toggles every HALF edges.
  - Duty cycle exactly 50% when CLK_FREQ_HZ is divisible by 2*BLINK_FREQ_HZ.
- Reset mid-operation: rst_async = 0 at any time, including between clock edges, forces led off and counter 0 immediately. Release restarts the sequence from the beginning with the same timing.
- Reset pulse shorter than one clock period must still fully reset all state.
- No X propagation: all flops have a defined reset value.
- Before the first reset, simulation state is don't-care; behaviour is required only after the first reset.

Test Plan:
- Default reset: CLK_FREQ_HZ=20, BLINK_FREQ_HZ=2 (HALF=5), 20 ns clock.
  - Stimulus: hold rst_async=0 for 3 cycles, then release.
  - Required: led=0 throughout reset; led=0 through edge 6 after release; led=1 after edge 7; led=0 after edge 12; led=1 after edge 17.
- Async assertion: same params, pull rst_async low 5 ns after a rising edge while led=1.
  - Required: led=0 within the same cycle before the next edge; counter reads 0.
- Mid-count re-reset: release reset, then reassert after 3 edges for 1 cycle and release.
  - Required: first toggle again occurs at edge 7 after the second release, with no carry-over of counter value.
- Active-low pin: LED_ACTIVE_LOW=1, HALF=5.
  - Required: led=1 during reset and through edge 6; led=0 after edge 7; period 10 cycles.
- Default params at 50 MHz, simulated for 60,000,000 cycles after release.
  - Required: first rising of led at edge 25,000,002.
  - Required: falling edge of led 25,000,000 cycles later; high and low times equal.
- Short reset glitch: rst_async low for 3 ns between edges, mid-blink.
  - Required: led forced off; sequence restarts with the first toggle at edge HALF+2 after the glitch ends.
